// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready handshake and a 2-entry skid buffer.
// Latency: 1 cycle from accept edge to out_valid/out_data. All outputs are flop outputs.
// Backpressure: with out_ready low, at most one more beat is taken into skid_q, then in_ready drops.
//
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   clr                    synchronous flush; empties the stage and reloads RESET_VAL
//   in_valid/in_ready      upstream handshake; in_ready is registered
//   in_data                upstream payload
//   out_valid/out_ready    downstream handshake
//   out_data               payload, driven straight from main_q
//   level                  occupancy 0..2
module pipe_skid_reg #(
  parameter int unsigned        WIDTH     = 32,
  parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       level
);

  // Encodings double as the occupancy count so level is a straight copy.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [1:0]       level_q;

  logic accept;
  logic consume;

  // Handshakes use the registered flags, so in_ready never sees out_ready
  // combinationally.
  assign accept  = in_valid && in_ready_q;
  assign consume = out_valid_q && out_ready;

  // Next-state and datapath selection.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (clr) begin
      // Flush wins over any handshake in the same cycle: the offered beat
      // and the presented beat are both discarded.
      state_d = EMPTY;
      main_d  = RESET_VAL;
      skid_d  = RESET_VAL;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_d = in_data;
          end else if (consume) begin
            // main_q intentionally keeps the stale beat; out_valid masks it.
            state_d = EMPTY;
          end else if (accept) begin
            skid_d  = in_data;
            state_d = TWO;
          end
        end
        TWO: begin
          // in_ready_q is low here, so accept cannot occur.
          if (consume) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // State, storage and output flags. The flags are computed from the next
  // state so they line up with the state on the same edge while still
  // coming straight out of flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_q      <= RESET_VAL;
      skid_q      <= RESET_VAL;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      level_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != TWO);
      out_valid_q <= (state_d != EMPTY);
      level_q     <= state_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign level     = level_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

  localparam logic [31:0] RV32 = 32'hDEAD_BEEF;
  localparam logic [7:0]  RV8  = 8'h5A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance for directed tests
  logic        rst, clr, in_valid, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [1:0]  level;

  pipe_skid_reg #(.WIDTH(32), .RESET_VAL(RV32)) u_dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level)
  );

  // 8-bit instance for the random handshake run
  logic       clr8, in_valid8, out_ready8;
  logic [7:0] in_data8;
  logic       in_ready8, out_valid8;
  logic [7:0] out_data8;
  logic [1:0] level8;

  pipe_skid_reg #(.WIDTH(8), .RESET_VAL(RV8)) u_dut8 (
    .clk(clk), .rst(rst), .clr(clr8),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .level(level8)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string name, input logic ev, input logic er,
                         input logic [1:0] el, input logic [31:0] ed);
    chk({name, ".out_valid"}, {31'd0, out_valid}, {31'd0, ev});
    chk({name, ".in_ready"},  {31'd0, in_ready},  {31'd0, er});
    chk({name, ".level"},     {30'd0, level},     {30'd0, el});
    chk({name, ".out_data"},  out_data, ed);
  endtask

  typedef struct {
    logic        clr;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        ev;
    logic        er;
    logic [1:0]  el;
    logic [31:0] ed;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic c, logic iv, logic [31:0] d, logic o,
                              logic ev, logic er, logic [1:0] el, logic [31:0] ed);
    vec_t v;
    v.clr = c; v.iv = iv; v.d = d; v.ordy = o;
    v.ev = ev; v.er = er; v.el = el; v.ed = ed;
    return v;
  endfunction

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    clr8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b0; in_data8 = '0;

    //            clr iv data        ordy  ov ir lvl out_data
    vecs.push_back(mk(0, 0, 32'h0,  0,    0, 1, 0, RV32));   // idle after reset
    vecs.push_back(mk(0, 1, 32'h1,  1,    1, 1, 1, 32'h1));  // EMPTY accept
    vecs.push_back(mk(0, 1, 32'h2,  1,    1, 1, 1, 32'h2));  // ONE accept+consume
    vecs.push_back(mk(0, 1, 32'h3,  1,    1, 1, 1, 32'h3));
    vecs.push_back(mk(0, 0, 32'h0,  1,    0, 1, 0, 32'h3));  // consume only, data kept
    vecs.push_back(mk(0, 1, 32'hA,  0,    1, 1, 1, 32'hA));  // 0xA appears, stall
    vecs.push_back(mk(0, 1, 32'hB,  0,    1, 0, 2, 32'hA));  // 0xB into skid
    vecs.push_back(mk(0, 1, 32'hC,  0,    1, 0, 2, 32'hA));  // 0xC held upstream
    vecs.push_back(mk(0, 1, 32'hC,  1,    1, 1, 1, 32'hB));  // release: skid->main
    vecs.push_back(mk(0, 1, 32'hC,  0,    1, 0, 2, 32'hB));  // 0xC accepted into skid
    vecs.push_back(mk(0, 0, 32'h0,  1,    1, 1, 1, 32'hC));
    vecs.push_back(mk(0, 0, 32'h0,  1,    0, 1, 0, 32'hC));
    vecs.push_back(mk(0, 1, 32'h5,  0,    1, 1, 1, 32'h5));  // build level 2
    vecs.push_back(mk(0, 1, 32'h6,  0,    1, 0, 2, 32'h5));
    vecs.push_back(mk(1, 1, 32'h7,  1,    0, 1, 0, RV32));   // flush in TWO
    vecs.push_back(mk(0, 0, 32'h0,  1,    0, 1, 0, RV32));   // 0x7 never appears
    vecs.push_back(mk(0, 1, 32'h8,  0,    1, 1, 1, 32'h8));
    vecs.push_back(mk(1, 1, 32'h9,  1,    0, 1, 0, RV32));   // flush in ONE
    vecs.push_back(mk(0, 1, 32'h11, 0,    1, 1, 1, 32'h11)); // refill after flush
    vecs.push_back(mk(0, 1, 32'h12, 0,    1, 0, 2, 32'h11));
    vecs.push_back(mk(0, 0, 32'h0,  1,    1, 1, 1, 32'h12));
    vecs.push_back(mk(0, 0, 32'h0,  1,    0, 1, 0, 32'h12));

    // Reset values while rst is held
    #12;
    chk_all("rst_held", 1'b0, 1'b1, 2'd0, RV32);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors: drive at negedge, check 1 after the rising edge
    foreach (vecs[i]) begin
      @(negedge clk);
      clr = vecs[i].clr; in_valid = vecs[i].iv; in_data = vecs[i].d; out_ready = vecs[i].ordy;
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].er, vecs[i].el, vecs[i].ed);
    end

    // Streaming 0x1..0x10 with out_ready high: no bubbles, 1-cycle latency
    @(negedge clk);
    clr = 1'b0; out_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      in_valid = 1'b1; in_data = k;
      @(posedge clk); #1;
      chk_all($sformatf("stream%0d", k), 1'b1, 1'b1, 2'd1, k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk_all("stream_drain", 1'b0, 1'b1, 2'd0, 32'h10);

    // Async reset between edges while level=1
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b0;
    @(posedge clk); #1;
    chk_all("pre_arst", 1'b1, 1'b1, 2'd1, 32'h77);
    #2 rst = 1'b1;
    #1;
    chk_all("arst_now", 1'b0, 1'b1, 2'd0, RV32);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_all("arst_after", 1'b0, 1'b1, 2'd0, RV32);

    // Random handshake on the 8-bit instance against a queue model
    begin
      logic [7:0] sb[$];
      logic [7:0] held;
      logic       was_stall;
      int         drops;
      drops = 0;
      was_stall = 1'b0;
      held = '0;
      for (int c = 0; c < 10000; c++) begin
        @(negedge clk);
        in_valid8  = ($urandom_range(0, 3) != 0);
        out_ready8 = ($urandom_range(0, 2) != 0);
        in_data8   = 8'($urandom);
        #1;
        if (level8 > 2'd2) begin
          tests++; fails++;
          $display("FAIL rnd_level: got %0d expected <=2", level8);
        end
        if (was_stall) chk("rnd_stable", {24'd0, out_data8}, {24'd0, held});
        if (out_valid8 && out_ready8) begin
          if (sb.size() == 0) begin
            tests++; fails++; drops++;
            $display("FAIL rnd_extra: got %h expected no beat", out_data8);
          end else begin
            chk("rnd_order", {24'd0, out_data8}, {24'd0, sb.pop_front()});
          end
        end
        if (in_valid8 && in_ready8) sb.push_back(in_data8);
        was_stall = out_valid8 && !out_ready8;
        held = out_data8;
        @(posedge clk);
      end
      @(negedge clk);
      in_valid8 = 1'b0; out_ready8 = 1'b0;
      #1;
      chk("rnd_final_level", {30'd0, level8}, sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
